// File: rtl/gf2m_pkg.sv
// ---------------------------------------------------------------------------
// gf2m_pkg
// Purpose : shared constants for the GF(2^M) datapath (default B/K-233,
//           f(x) = x^233 + x^74 + 1) and the reduction FSM state type.
//           The multiplier top uses the same constants for width checks.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package gf2m_pkg;

    localparam int unsigned M  = 233;        // field degree
    localparam int unsigned K  = 74;         // trinomial middle term, 1 <= K <= (M-1)/2
    localparam int unsigned PW = 2 * M - 1;  // unreduced product width

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFold = 2'd1,
        StHold = 2'd2
    } red_state_e;

endpackage

// File: rtl/gf2m_reduce_seq_if.sv
// ---------------------------------------------------------------------------
// gf2m_reduce_seq_if
// Purpose : handshake bundle between the multiplier, the reduction stage and
//           its consumer.
// Signals : in_valid/in_ready/in_prod   product input handshake
//           out_valid/out_ready/out_res result output handshake
//           fold_cnt                    folds used for current/last result
//           busy                        reducer not idle
// Modports: master drives products and out_ready; slave is the reducer.
// ---------------------------------------------------------------------------
interface gf2m_reduce_seq_if #(
    parameter int unsigned M = gf2m_pkg::M
);
    localparam int unsigned PW = 2 * M - 1;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_res;
    logic [1:0]    fold_cnt;
    logic          busy;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_res, fold_cnt, busy
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_res, fold_cnt, busy
    );

endinterface

// File: rtl/gf2m_fold.sv
// ---------------------------------------------------------------------------
// gf2m_fold
// Purpose : one combinational fold of a GF(2)[x] polynomial modulo the
//           trinomial x^M + x^K + 1, using x^M == x^K + 1:
//             out = lo ^ hi ^ (hi << K), hi = in[PW-1:M], lo = in[M-1:0]
// Ports   : i_acc   [PW-1:0] polynomial to fold
//           o_acc   [PW-1:0] folded polynomial
//           o_hi_nz          any coefficient at or above x^M is set
// ---------------------------------------------------------------------------
module gf2m_fold #(
    parameter int unsigned M = 233,
    parameter int unsigned K = 74
) (
    input  logic [2*M-2:0] i_acc,
    output logic [2*M-2:0] o_acc,
    output logic           o_hi_nz
);
    localparam int unsigned PW = 2 * M - 1;

    logic [M-2:0]  w_hi;
    logic [PW-1:0] w_lo_ext;
    logic [PW-1:0] w_hi_ext;

    assign w_hi     = i_acc[PW-1:M];
    assign w_lo_ext = {{(M-1){1'b0}}, i_acc[M-1:0]};
    assign w_hi_ext = {{M{1'b0}}, w_hi};

    // hi << K reaches degree M-2+K < PW, so nothing falls off the top.
    assign o_acc   = w_lo_ext ^ w_hi_ext ^ (w_hi_ext << K);
    assign o_hi_nz = |w_hi;

endmodule

// File: rtl/gf2m_reduce_seq.sv
// ---------------------------------------------------------------------------
// gf2m_reduce_seq
// Purpose : sequential reduction of an unreduced 2M-1 bit GF(2)[x] product
//           modulo x^M + x^K + 1, one fold per clock, result returned over a
//           valid/ready handshake.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset; aborts any in-flight product
//           bus    gf2m_reduce_seq_if.slave (product in, result out, debug)
// ---------------------------------------------------------------------------
module gf2m_reduce_seq
    import gf2m_pkg::*;
#(
    parameter int unsigned M = gf2m_pkg::M,
    parameter int unsigned K = gf2m_pkg::K
) (
    input  logic              clk,
    input  logic              rst_n,
    gf2m_reduce_seq_if.slave  bus
);
    localparam int unsigned PW = 2 * M - 1;

    red_state_e    r_state;
    red_state_e    w_state_d;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] w_acc_d;
    logic [M-1:0]  r_res;
    logic [M-1:0]  w_res_d;
    logic [1:0]    r_fold_cnt;
    logic [1:0]    w_fold_cnt_d;
    logic [PW-1:0] w_fold_acc;
    logic          w_hi_nz;

    gf2m_fold #(
        .M (M),
        .K (K)
    ) u_fold (
        .i_acc   (r_acc),
        .o_acc   (w_fold_acc),
        .o_hi_nz (w_hi_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_acc      <= '0;
            r_res      <= '0;
            r_fold_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_acc      <= w_acc_d;
            r_res      <= w_res_d;
            r_fold_cnt <= w_fold_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_acc_d      = r_acc;
        w_res_d      = r_res;
        w_fold_cnt_d = r_fold_cnt;
        unique case (r_state)
            StIdle: begin
                // in_ready is implied by being in StIdle
                if (bus.in_valid) begin
                    w_acc_d      = bus.in_prod;
                    w_fold_cnt_d = '0;
                    w_state_d    = StFold;
                end
            end
            StFold: begin
                if (w_hi_nz) begin
                    w_acc_d      = w_fold_acc;
                    w_fold_cnt_d = r_fold_cnt + 2'd1;
                end else begin
                    w_res_d   = r_acc[M-1:0];
                    w_state_d = StHold;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StHold);
    assign bus.busy      = (r_state != StIdle);
    assign bus.out_res   = r_res;
    assign bus.fold_cnt  = r_fold_cnt;

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// ---------------------------------------------------------------------------
// tb_gf2m_reduce_seq
// Purpose : scoreboard bench for gf2m_reduce_seq. Stimulus pushes expected
//           results; a monitor pops and compares on each output handshake.
//           Reference: carry-less multiply plus bitwise long division.
// ---------------------------------------------------------------------------
module tb_gf2m_reduce_seq;
    import gf2m_pkg::*;

    typedef struct {
        logic [M-1:0] res;
        int unsigned  folds;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    gf2m_reduce_seq_if #(.M(M)) bus ();

    gf2m_reduce_seq #(
        .M (M),
        .K (K)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   results = 0;
    int   pushed  = 0;
    bit   rand_stall = 1'b0;

    task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [PW-1:0] rand_bits();
        logic [PW-1:0] r;
        for (int i = 0; i < int'(PW); i++) r[i] = 1'($urandom_range(1));
        return r;
    endfunction

    function automatic logic [PW-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [PW-1:0] r;
        logic [PW-1:0] ae;
        r  = '0;
        ae = PW'(a);
        for (int i = 0; i < int'(M); i++) if (b[i]) r ^= ae << i;
        return r;
    endfunction

    // Long division: cancel the top coefficient using x^M = x^K + 1.
    function automatic logic [M-1:0] poly_mod(input logic [PW-1:0] p);
        for (int i = int'(PW) - 1; i >= int'(M); i--) begin
            if (p[i]) begin
                p[i]                    = 1'b0;
                p[i - int'(M) + int'(K)] ^= 1'b1;
                p[i - int'(M)]          ^= 1'b1;
            end
        end
        return p[M-1:0];
    endfunction

    // Each fold maps degree d to d-M+K; count folds until d < M.
    function automatic int unsigned exp_folds(input logic [PW-1:0] p);
        int          d = -1;
        int unsigned n = 0;
        for (int i = 0; i < int'(PW); i++) if (p[i]) d = i;
        while (d >= int'(M)) begin
            d = d - int'(M) + int'(K);
            n++;
        end
        return n;
    endfunction

    // Call at posedge+#1; returns at posedge+#1 just after the accept edge.
    task automatic send(input logic [PW-1:0] p, input logic [M-1:0] res,
                        input int unsigned f, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        while (!ok && n < 60) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_prod  = rand_bits();
        if (ok) begin
            exp_q.push_back('{res: res, folds: f});
            pushed++;
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, required in_ready=1");
        end
    endtask

    // Returns latency in cycles from the accept edge to out_valid.
    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        lat = n - 1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h, required no result", bus.out_res);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.out_res, e.res);
                    check("fold_cnt", M'(bus.fold_cnt), M'(e.folds));
                    check("fold_bound", M'(bus.fold_cnt <= 2'd2), M'(1));
                    results++;
                end
            end
        end
    end

    // FOLD-cycle watchdog: more than 3 consecutive fold cycles is a design error.
    initial begin
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.busy && !bus.out_valid) run++;
            else run = 0;
            if (run > 3) begin
                checks++;
                errors++;
                $display("FAIL fold_cycles: got %0d, required <= 3", run);
                run = 0;
            end
        end
    end

    // Random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) bus.out_ready = ($urandom_range(3) != 0);
        end
    end

    initial begin
        logic [PW-1:0] p;
        logic [PW-1:0] tmp;
        logic [M-1:0]  a;
        logic [M-1:0]  b;
        logic [M-1:0]  r;
        bit            ok;
        int            lat;
        int            n;

        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", M'(bus.in_ready), M'(1));
        check("rst_out_valid", M'(bus.out_valid), M'(0));
        check("rst_busy", M'(bus.busy), M'(0));
        check("rst_fold_cnt", M'(bus.fold_cnt), M'(0));
        check("rst_out_res", bus.out_res, M'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // x^0 passes through, latency 1, in_ready returns a cycle after handshake
        p = '0; p[0] = 1'b1;
        r = '0; r[0] = 1'b1;
        send(p, r, 0, ok);
        wait_valid(lat);
        check("lat_x0", M'(lat), M'(1));
        @(negedge clk);
        check("x0_in_ready_back", M'(bus.in_ready), M'(1));
        check("x0_out_valid_low", M'(bus.out_valid), M'(0));
        @(posedge clk);
        #1;

        // x^233 -> x^74 + 1, one fold
        p = '0; p[233] = 1'b1;
        r = '0; r[74] = 1'b1; r[0] = 1'b1;
        send(p, r, 1, ok);
        wait_valid(lat);
        check("lat_x233", M'(lat), M'(2));
        @(posedge clk);
        #1;

        // x^464 -> x^231 + x^146 + x^72, two folds
        p = '0; p[464] = 1'b1;
        r = '0; r[231] = 1'b1; r[146] = 1'b1; r[72] = 1'b1;
        send(p, r, 2, ok);
        wait_valid(lat);
        check("lat_x464", M'(lat), M'(3));
        @(posedge clk);
        #1;

        // Backpressure: hold result 5 cycles, ignore a pulsed in_valid
        bus.out_ready = 1'b0;
        p = '0; p[233] = 1'b1;
        r = '0; r[74] = 1'b1; r[0] = 1'b1;
        send(p, r, 1, ok);
        wait_valid(lat);
        check("lat_bp", M'(lat), M'(2));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.in_prod  = PW'(1);
            end
            if (i == 2) bus.in_valid = 1'b0;
            @(negedge clk);
            check("bp_out_valid", M'(bus.out_valid), M'(1));
            check("bp_out_res", bus.out_res, r);
            check("bp_in_ready", M'(bus.in_ready), M'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_back", M'(bus.in_ready), M'(1));
        @(posedge clk);
        #1;
        p = '0; p[5] = 1'b1;
        r = '0; r[5] = 1'b1;
        send(p, r, 0, ok);
        wait_valid(lat);
        check("lat_after_bp", M'(lat), M'(1));
        @(posedge clk);
        #1;

        // Reset mid-FOLD aborts the operation
        p = '0; p[464] = 1'b1;
        r = '0; r[231] = 1'b1; r[146] = 1'b1; r[72] = 1'b1;
        send(p, r, 2, ok);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", M'(bus.out_valid), M'(0));
        check("arst_out_res", bus.out_res, M'(0));
        check("arst_fold_cnt", M'(bus.fold_cnt), M'(0));
        check("arst_busy", M'(bus.busy), M'(0));
        check("arst_in_ready", M'(bus.in_ready), M'(1));
        exp_q.delete();
        pushed--;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale", M'(bus.out_valid), M'(0));
        end
        @(posedge clk);
        #1;
        p = '0; p[0] = 1'b1;
        r = '0; r[0] = 1'b1;
        send(p, r, 0, ok);
        wait_valid(lat);
        check("lat_after_rst", M'(lat), M'(1));
        @(posedge clk);
        #1;

        // Random regression with stalls
        rand_stall = 1'b1;
        for (int v = 0; v < 10000; v++) begin
            tmp = rand_bits();
            a   = tmp[M-1:0];
            tmp = rand_bits();
            b   = tmp[M-1:0];
            if (v % 50 == 7) a = '0;
            if (v % 37 == 3) b = M'(1);
            p = clmul(a, b);
            send(p, poly_mod(p), exp_folds(p), ok);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rand_stall = 1'b0;
        check("drain_pending", M'(exp_q.size()), M'(0));
        check("result_count", M'(results), M'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
